uart_baud_scheduler: RTL and testbench
======================================

Name: uart_baud_scheduler

Overview:
Programmable baud-tick scheduler for the UART. It produces the oversample tick and the bit tick that sequence the TX and RX datapaths, in place of a fixed-divisor clock divider. Divisor changes arrive through a valid/ready handshake and are applied only on a bit boundary, so a frame in flight never sees a partial bit. The RX path can re-phase the counters on start-bit detection.

Parameters:
DIVISOR_WIDTH, 16, width of divisor and oversample counter
OVERSAMPLE, 16, oversample ticks per bit (must be 2 or more)
DEFAULT_DIVISOR, 4, divisor loaded at reset (must be 2 or more)

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = run tick generation, 0 = idle
phase_sync  input  1  single-cycle pulse; restarts both counters
cfg_divisor  input  DIVISOR_WIDTH  requested clock cycles per oversample tick
cfg_valid  input  1  cfg_divisor valid
cfg_ready  output  1  scheduler can accept cfg_divisor
active_divisor  output  DIVISOR_WIDTH  divisor currently in use
tick_os  output  1  one-cycle oversample tick
tick_bit  output  1  one-cycle bit tick, coincident with every OVERSAMPLE-th tick_os
running  output  1  state is RUN or PENDING

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state IDLE; os_cnt=0; bit_cnt=0
  - tick_os=0; tick_bit=0; running=0; cfg_ready=1
  - active_divisor=DEFAULT_DIVISOR; shadow register=0
- All outputs are registered.
- Divisor acceptance: a value below 2 is clamped to 2 when accepted; active_divisor never holds 0 or 1.
- State IDLE:
  - Counters held at 0; no ticks; cfg_ready=1.
  - On a cfg handshake, active_divisor takes the new value on the next edge.
  - enable=1 moves to RUN on the next edge.
- State RUN:
  - os_cnt increments every cycle.
  - When os_cnt==active_divisor-1: os_cnt wraps to 0, tick_os=1 on the next cycle, bit_cnt increments.
  - When bit_cnt wraps from OVERSAMPLE-1 to 0, tick_bit=1 in the same cycle as that tick_os.
  - cfg_ready=1. A handshake stores the clamped value in the shadow register and moves to PENDING.
- State PENDING:
  - Counts exactly as RUN; cfg_ready=0.
  - On the cycle tick_bit is asserted: active_divisor loads the shadow value, both counters restart from 0, state returns to RUN.
  - The next tick_os after the switch occurs new-divisor cycles later.
- Timing:
  - The first tick_os comes exactly active_divisor+1 rising edges after the edge that samples enable=1 (1 edge for IDLE->RUN, then active_divisor edges of counting).
  - After that, the tick_os period is exactly active_divisor cycles.
- phase_sync in RUN or PENDING:
  - Clears os_cnt and bit_cnt on the next edge; no tick_os or tick_bit in that next cycle.
  - A PENDING divisor is applied at the same edge and the state returns to RUN.
  - Ignored in IDLE.
- Priority of simultaneous events: enable=0, then phase_sync, then counter wrap.
- enable=0 in RUN or PENDING: state goes to IDLE on the next edge and counters clear; a pending shadow value is applied at that edge, not discarded.
- Reset in the middle of PENDING discards the shadow value; active_divisor returns to DEFAULT_DIVISOR.
- Counter width: os_cnt is DIVISOR_WIDTH bits. bit_cnt is clog2(OVERSAMPLE) bits, wrapping explicitly at OVERSAMPLE-1 (supports OVERSAMPLE that is not a power of 2).

Optional Feature:
UART_BAUD_FRAC_EN
- Defined:
  - Adds input port cfg_frac (4 bits), captured together with cfg_divisor through the same handshake and staging path.
  - A 4-bit phase accumulator adds the active fraction at every tick_os.
  - On accumulator carry, the next oversample period is active_divisor+1 cycles; otherwise it is active_divisor.
  - Over 16 ticks, the average period is active_divisor + cfg_frac/16.
  - The accumulator clears on reset, on IDLE, on phase_sync and on divisor switch.
- Undefined: cfg_frac port absent; behaviour is integer-only as above.

Test Plan:
- Reset, enable=1 held, divisor 4, OVERSAMPLE 16 -> first tick_os at edge 5 after enable is sampled, then every 4 cycles; tick_bit every 64 cycles, coincident with every 16th tick_os.
- In IDLE, cfg_divisor=10 with cfg_valid=1 -> active_divisor=10 next cycle; after enable, tick_os period is 10.
- In RUN at divisor 4, write 6 mid-bit -> cfg_ready=0; tick_os period stays 4 until tick_bit; afterwards period is 6, cfg_ready=1, no partial bit.
- phase_sync pulse mid-bit at divisor 4 -> no tick in the next cycle; next tick_os 4 cycles after the clear; next tick_bit after 16 further ticks.
- cfg_divisor=0 and cfg_divisor=1 -> active_divisor=2; tick_os alternates every 2 cycles.
- With UART_BAUD_FRAC_EN, divisor 4 and frac 8 -> tick_os periods alternate 4,5 (16 ticks span 72 cycles). Drop rst mid-PENDING -> all outputs at reset values, active_divisor=4.

Source files
------------

// File: rtl/uart_baud_scheduler.sv
// Programmable oversample/bit tick scheduler for the UART, with bit-boundary divisor switching.
// Optional fractional divisor support is enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_scheduler #(
    parameter int unsigned DIVISOR_WIDTH   = 16,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned DEFAULT_DIVISOR = 4
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     phase_sync,
    input  logic [DIVISOR_WIDTH-1:0] cfg_divisor,
    input  logic                     cfg_valid,
`ifdef UART_BAUD_FRAC_EN
    input  logic [3:0]               cfg_frac,
`endif
    output logic                     cfg_ready,
    output logic [DIVISOR_WIDTH-1:0] active_divisor,
    output logic                     tick_os,
    output logic                     tick_bit,
    output logic                     running
);

    localparam int unsigned BIT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OVERSAMPLE - 1);
    localparam logic [DIVISOR_WIDTH-1:0] DIV_MIN = DIVISOR_WIDTH'(2);
    localparam logic [DIVISOR_WIDTH-1:0] DIV_DEF = DIVISOR_WIDTH'(DEFAULT_DIVISOR);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [DIVISOR_WIDTH-1:0] os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DIVISOR_WIDTH-1:0] div_q, div_d;
    logic [DIVISOR_WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0]               frac_q, frac_d;
    logic [3:0]               shadow_frac_q, shadow_frac_d;
    logic [3:0]               acc_q, acc_d;
    logic                     extra_q, extra_d;
    logic                     tick_os_q, tick_os_d;
    logic                     tick_bit_q, tick_bit_d;
    logic                     running_q, running_d;
    logic                     ready_q, ready_d;

    logic [3:0]               frac_in;
    logic [DIVISOR_WIDTH-1:0] div_clamped;
    logic [DIVISOR_WIDTH-1:0] os_last;
    logic [4:0]               frac_sum;
    logic                     cfg_fire;
    logic                     wrap;

`ifdef UART_BAUD_FRAC_EN
    assign frac_in = cfg_frac;
`else
    assign frac_in = 4'd0;
`endif

    // A carry from the phase accumulator stretches the current period by one cycle.
    assign cfg_fire    = cfg_valid && ready_q;
    assign div_clamped = (cfg_divisor < DIV_MIN) ? DIV_MIN : cfg_divisor;
    assign os_last     = div_q - DIVISOR_WIDTH'(1) + DIVISOR_WIDTH'(extra_q);
    assign wrap        = (os_cnt_q == os_last);
    assign frac_sum    = {1'b0, acc_q} + {1'b0, frac_q};

    always_comb begin
        state_d       = state_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        div_d         = div_q;
        shadow_d      = shadow_q;
        frac_d        = frac_q;
        shadow_frac_d = shadow_frac_q;
        acc_d         = acc_q;
        extra_d       = extra_q;
        tick_os_d     = 1'b0;
        tick_bit_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                acc_d     = '0;
                extra_d   = 1'b0;
                if (cfg_fire) begin
                    div_d  = div_clamped;
                    frac_d = frac_in;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PENDING: begin
                if (!enable) begin
                    // Leaving RUN/PENDING commits any staged divisor rather than dropping it.
                    state_d   = ST_IDLE;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    acc_d     = '0;
                    extra_d   = 1'b0;
                    if (state_q == ST_PENDING) begin
                        div_d  = shadow_q;
                        frac_d = shadow_frac_q;
                    end else if (cfg_fire) begin
                        div_d  = div_clamped;
                        frac_d = frac_in;
                    end
                end else if (phase_sync) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    acc_d     = '0;
                    extra_d   = 1'b0;
                    if (state_q == ST_PENDING) begin
                        div_d   = shadow_q;
                        frac_d  = shadow_frac_q;
                        state_d = ST_RUN;
                    end else if (cfg_fire) begin
                        shadow_d      = div_clamped;
                        shadow_frac_d = frac_in;
                        state_d       = ST_PENDING;
                    end
                end else begin
                    if (wrap) begin
                        os_cnt_d  = '0;
                        tick_os_d = 1'b1;
                        acc_d     = frac_sum[3:0];
                        extra_d   = frac_sum[4];
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d  = '0;
                            tick_bit_d = 1'b1;
                            if (state_q == ST_PENDING) begin
                                div_d   = shadow_q;
                                frac_d  = shadow_frac_q;
                                acc_d   = '0;
                                extra_d = 1'b0;
                                state_d = ST_RUN;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + DIVISOR_WIDTH'(1);
                    end
                    if ((state_q == ST_RUN) && cfg_fire) begin
                        shadow_d      = div_clamped;
                        shadow_frac_d = frac_in;
                        state_d       = ST_PENDING;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d != ST_IDLE);
        ready_d   = (state_d != ST_PENDING);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            div_q         <= DIV_DEF;
            shadow_q      <= '0;
            frac_q        <= '0;
            shadow_frac_q <= '0;
            acc_q         <= '0;
            extra_q       <= 1'b0;
            tick_os_q     <= 1'b0;
            tick_bit_q    <= 1'b0;
            running_q     <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            div_q         <= div_d;
            shadow_q      <= shadow_d;
            frac_q        <= frac_d;
            shadow_frac_q <= shadow_frac_d;
            acc_q         <= acc_d;
            extra_q       <= extra_d;
            tick_os_q     <= tick_os_d;
            tick_bit_q    <= tick_bit_d;
            running_q     <= running_d;
            ready_q       <= ready_d;
        end
    end

    assign cfg_ready      = ready_q;
    assign active_divisor = div_q;
    assign tick_os        = tick_os_q;
    assign tick_bit       = tick_bit_q;
    assign running        = running_q;

endmodule

// File: tb/tb_uart_baud_scheduler.sv
// Directed self-checking bench for uart_baud_scheduler (DIVISOR_WIDTH 16, OVERSAMPLE 16, default divisor 4).
// Fractional-divisor vectors run only when UART_BAUD_FRAC_EN is defined.
module tb_uart_baud_scheduler;

    logic        clk_in;
    logic        rst;
    logic        enable;
    logic        phase_sync;
    logic [15:0] cfg_divisor;
    logic        cfg_valid;
`ifdef UART_BAUD_FRAC_EN
    logic [3:0]  cfg_frac;
`endif
    logic        cfg_ready;
    logic [15:0] active_divisor;
    logic        tick_os;
    logic        tick_bit;
    logic        running;

    int n_checks = 0;
    int n_errors = 0;

    uart_baud_scheduler #(
        .DIVISOR_WIDTH  (16),
        .OVERSAMPLE     (16),
        .DEFAULT_DIVISOR(4)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .enable        (enable),
        .phase_sync    (phase_sync),
        .cfg_divisor   (cfg_divisor),
        .cfg_valid     (cfg_valid),
`ifdef UART_BAUD_FRAC_EN
        .cfg_frac      (cfg_frac),
`endif
        .cfg_ready     (cfg_ready),
        .active_divisor(active_divisor),
        .tick_os       (tick_os),
        .tick_bit      (tick_bit),
        .running       (running)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Edges until the selected tick (0 = tick_os, 1 = tick_bit) is seen; -1 on timeout.
    task automatic count_until(input int sel, input int budget, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < budget) begin
            i++;
            step();
            if ((sel == 0 && tick_os) || (sel == 1 && tick_bit)) n = i;
        end
    endtask

    task automatic cfg_write(input int div);
        cfg_divisor = 16'(div);
        cfg_valid   = 1'b1;
        step();
        cfg_valid   = 1'b0;
    endtask

    initial begin
        int n;
        int sum;
        rst         = 1'b1;
        enable      = 1'b0;
        phase_sync  = 1'b0;
        cfg_divisor = '0;
        cfg_valid   = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        cfg_frac    = '0;
`endif
        #3 rst = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_tick_os", tick_os, 0);
        chk("rst_tick_bit", tick_bit, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_div", active_divisor, 4);

        // First tick after enable, steady period, bit tick spacing
        rst    = 1'b1;
        enable = 1'b1;
        count_until(0, 50, n);
        chk("first_os", n, 5);
        chk("run_running", running, 1);
        count_until(0, 50, n);
        chk("os_period4", n, 4);
        count_until(1, 200, n);
        chk("first_bit", n, 56);
        chk("bit_with_os", tick_os, 1);
        count_until(1, 200, n);
        chk("bit_period", n, 64);

        // phase_sync on the edge that would otherwise wrap
        count_until(0, 50, n);
        chk("ps_pre_os", n, 4);
        step(); step(); step();
        phase_sync = 1'b1;
        step();
        phase_sync = 1'b0;
        chk("ps_no_os", tick_os, 0);
        chk("ps_no_bit", tick_bit, 0);
        count_until(0, 50, n);
        chk("ps_next_os", n, 4);
        count_until(1, 200, n);
        chk("ps_next_bit", n, 60);

        // Divisor 4 -> 6 mid-bit, applied only at the bit boundary
        count_until(0, 50, n);
        chk("chg_pre_os", n, 4);
        cfg_write(6);
        chk("pend_ready", cfg_ready, 0);
        chk("pend_div_old", active_divisor, 4);
        count_until(0, 50, n);
        chk("pend_os_a", n, 3);
        count_until(0, 50, n);
        chk("pend_os_b", n, 4);
        count_until(1, 200, n);
        chk("pend_bit", n, 52);
        chk("switch_ready", cfg_ready, 1);
        chk("switch_div", active_divisor, 6);
        count_until(0, 50, n);
        chk("new_period6", n, 6);
        count_until(1, 200, n);
        chk("new_bit_span", n, 90);

        // IDLE configuration takes effect immediately
        enable = 1'b0;
        step();
        chk("idle_running", running, 0);
        chk("idle_tick_os", tick_os, 0);
        cfg_write(10);
        chk("idle_div10", active_divisor, 10);
        enable = 1'b1;
        count_until(0, 50, n);
        chk("first_os10", n, 11);
        count_until(0, 50, n);
        chk("os_period10", n, 10);

        // Divisor clamping
        enable = 1'b0;
        step();
        cfg_write(0);
        chk("clamp0", active_divisor, 2);
        cfg_write(3);
        chk("noclamp3", active_divisor, 3);
        cfg_write(1);
        chk("clamp1", active_divisor, 2);
        enable = 1'b1;
        count_until(0, 50, n);
        chk("first_os2", n, 3);
        count_until(0, 50, n);
        chk("os_period2_a", n, 2);
        count_until(0, 50, n);
        chk("os_period2_b", n, 2);

        // enable=0 while PENDING commits the staged divisor
        cfg_write(5);
        chk("pend2_ready", cfg_ready, 0);
        chk("pend2_div", active_divisor, 2);
        enable = 1'b0;
        step();
        chk("dis_apply_div", active_divisor, 5);
        chk("dis_running", running, 0);
        chk("dis_ready", cfg_ready, 1);

        // Asynchronous reset in the middle of PENDING
        enable = 1'b1;
        step();
        cfg_write(7);
        chk("pend3_ready", cfg_ready, 0);
        chk("pend3_div", active_divisor, 5);
        rst = 1'b0;
        #1;
        chk("mrst_div", active_divisor, 4);
        chk("mrst_ready", cfg_ready, 1);
        chk("mrst_running", running, 0);
        chk("mrst_tick_os", tick_os, 0);
        chk("mrst_tick_bit", tick_bit, 0);
        enable = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("post_rst_div", active_divisor, 4);

`ifdef UART_BAUD_FRAC_EN
        // Divisor 4 with fraction 8/16: periods 4,5 alternate after the first
        cfg_divisor = 16'd4;
        cfg_frac    = 4'd8;
        cfg_valid   = 1'b1;
        step();
        cfg_valid   = 1'b0;
        enable      = 1'b1;
        count_until(0, 50, n);
        chk("frac_first", n, 5);
        count_until(0, 50, n);
        chk("frac_p2", n, 4);
        sum = n;
        count_until(0, 50, n);
        chk("frac_p3", n, 5);
        sum += n;
        for (int k = 0; k < 14; k++) begin
            count_until(0, 50, n);
            sum += n;
        end
        chk("frac_span16", sum, 72);
        enable = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
